// File: rtl/clock_display.sv
// Purpose: multiplexed 8-digit 7-segment driver showing HH-MM-SS with adjust-field blink and chime LED.
// Latency: an/seg/led are registered, one clk after the digit index or blink phase changes.
// Backpressure: none; free-running scan, time inputs are sampled once per frame.
// Ports: clk/rst (async, active-high); hours/minutes/seconds binary time; adj_mode field select
//        (0/3 normal, 1 hours, 2 minutes); chime level; an active-low digit enables (bit i = digit i);
//        seg active-low segments {dp,g..a}; led chime indicator, active-high.
module clock_display #(
    parameter int SCAN_DIV  = 2500,
    parameter int BLINK_DIV = 250000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] hours,
    input  logic [7:0] minutes,
    input  logic [7:0] seconds,
    input  logic [1:0] adj_mode,
    input  logic       chime,
    output logic [7:0] an,
    output logic [7:0] seg,
    output logic       led
);

    localparam int SW = (SCAN_DIV  > 2) ? $clog2(SCAN_DIV)  : 1;
    localparam int BW = (BLINK_DIV > 2) ? $clog2(BLINK_DIV) : 1;

    localparam logic [SW-1:0] SCAN_LAST  = SW'(SCAN_DIV - 1);
    localparam logic [SW-1:0] SCAN_ONE   = SW'(1);
    localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_DIV - 1);
    localparam logic [BW-1:0] BLINK_ONE  = BW'(1);

    // Internal digit symbols: 0..9 are decimal digits, the rest are glyphs.
    localparam logic [3:0] DIG_DASH  = 4'hA;
    localparam logic [3:0] DIG_E     = 4'hE;
    localparam logic [3:0] DIG_BLANK = 4'hF;

    logic [SW-1:0] scan_cnt;
    logic [2:0]    idx;
    logic [7:0]    hr_q;
    logic [7:0]    min_q;
    logic [7:0]    sec_q;
    logic [BW-1:0] blink_cnt;
    logic          blink_phase;
    logic [1:0]    adj_prev;

    logic          scan_wrap;
    logic          frame_wrap;
    logic          blank_hr;
    logic          blank_min;
    logic [3:0]    digit;
    logic [7:0]    seg_nxt;

    function automatic logic [3:0] tens_of(input logic [7:0] v);
        logic [7:0] q;
        q = v / 8'd10;
        if (v > 8'd99) tens_of = DIG_E;
        else           tens_of = q[3:0];
    endfunction

    function automatic logic [3:0] ones_of(input logic [7:0] v);
        logic [7:0] r;
        r = v % 8'd10;
        if (v > 8'd99) ones_of = DIG_E;
        else           ones_of = r[3:0];
    endfunction

    function automatic logic [7:0] seg_of(input logic [3:0] d);
        case (d)
            4'd0:    seg_of = 8'hC0;
            4'd1:    seg_of = 8'hF9;
            4'd2:    seg_of = 8'hA4;
            4'd3:    seg_of = 8'hB0;
            4'd4:    seg_of = 8'h99;
            4'd5:    seg_of = 8'h92;
            4'd6:    seg_of = 8'h82;
            4'd7:    seg_of = 8'hF8;
            4'd8:    seg_of = 8'h80;
            4'd9:    seg_of = 8'h90;
            DIG_DASH: seg_of = 8'hBF;
            DIG_E:   seg_of = 8'h86;
            default: seg_of = 8'hFF;
        endcase
    endfunction

    assign scan_wrap  = (scan_cnt == SCAN_LAST);
    assign frame_wrap = scan_wrap && (idx == 3'd7);

    // Scan prescaler, digit index, and once-per-frame snapshot so a frame never mixes two times.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            scan_cnt <= '0;
            idx      <= 3'd0;
            hr_q     <= 8'd0;
            min_q    <= 8'd0;
            sec_q    <= 8'd0;
        end else begin
            if (scan_wrap) begin
                scan_cnt <= '0;
                idx      <= idx + 3'd1;
            end else begin
                scan_cnt <= scan_cnt + SCAN_ONE;
            end
            if (frame_wrap) begin
                hr_q  <= hours;
                min_q <= minutes;
                sec_q <= seconds;
            end
        end
    end

    // Blink timebase; restarts in the visible phase whenever the adjust field changes.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            blink_cnt   <= '0;
            blink_phase <= 1'b0;
            adj_prev    <= 2'd0;
        end else begin
            adj_prev <= adj_mode;
            if (adj_mode != adj_prev) begin
                blink_cnt   <= '0;
                blink_phase <= 1'b0;
            end else if (blink_cnt == BLINK_LAST) begin
                blink_cnt   <= '0;
                blink_phase <= ~blink_phase;
            end else begin
                blink_cnt <= blink_cnt + BLINK_ONE;
            end
        end
    end

    assign blank_hr  = (adj_mode == 2'd1) && blink_phase;
    assign blank_min = (adj_mode == 2'd2) && blink_phase;

    always_comb begin
        digit = DIG_BLANK;
        case (idx)
            3'd0: digit = ones_of(sec_q);
            3'd1: digit = tens_of(sec_q);
            3'd2: digit = DIG_DASH;
            3'd3: digit = blank_min ? DIG_BLANK : ones_of(min_q);
            3'd4: digit = blank_min ? DIG_BLANK : tens_of(min_q);
            3'd5: digit = DIG_DASH;
            3'd6: digit = blank_hr ? DIG_BLANK : ones_of(hr_q);
            3'd7: digit = blank_hr ? DIG_BLANK : tens_of(hr_q);
            default: digit = DIG_BLANK;
        endcase
        seg_nxt = seg_of(digit);
    end

    // Blanked digits keep their enable asserted; only the segments go dark.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            an  <= 8'hFF;
            seg <= 8'hFF;
            led <= 1'b0;
        end else begin
            an  <= ~(8'd1 << idx);
            seg <= seg_nxt;
            led <= chime & ~blink_phase;
        end
    end

endmodule

// File: tb/tb_clock_display.sv
// Purpose: directed self-checking bench for clock_display with SCAN_DIV=4, BLINK_DIV=16.
// Latency: outputs sampled 1 time unit after each rising clk edge.
// Backpressure: not applicable.
module tb_clock_display;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] hours;
    logic [7:0] minutes;
    logic [7:0] seconds;
    logic [1:0] adj_mode;
    logic       chime;
    logic [7:0] an;
    logic [7:0] seg;
    logic       led;

    int total = 0;
    int bad   = 0;
    int t     = 0;   // rising edges since the last reset release

    clock_display #(.SCAN_DIV(4), .BLINK_DIV(16)) dut (
        .clk      (clk),
        .rst      (rst),
        .hours    (hours),
        .minutes  (minutes),
        .seconds  (seconds),
        .adj_mode (adj_mode),
        .chime    (chime),
        .an       (an),
        .seg      (seg),
        .led      (led)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
        t++;
    endtask

    // Digit slot whose enable is visible after edge t (registered outputs lag idx by one edge).
    function automatic int slot_now();
        return ((t - 1) / 4) % 8;
    endfunction

    task automatic test_reset();
        hours    = 8'd12;
        minutes  = 8'd34;
        seconds  = 8'd56;
        adj_mode = 2'd0;
        chime    = 1'b0;
        rst      = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            total++;
            if (an !== 8'hFF) begin bad++; $display("FAIL reset_an cyc=%0d got=%h want=FF", i, an); end
            total++;
            if (seg !== 8'hFF) begin bad++; $display("FAIL reset_seg cyc=%0d got=%h want=FF", i, seg); end
            total++;
            if (led !== 1'b0) begin bad++; $display("FAIL reset_led cyc=%0d got=%b want=0", i, led); end
        end
        @(negedge clk);
        rst = 1'b0;
        t   = 0;
        step();
        total++;
        if (an !== 8'hFE) begin bad++; $display("FAIL first_edge_an got=%h want=FE", an); end
        total++;
        if (seg !== 8'hC0) begin bad++; $display("FAIL first_edge_seg got=%h want=C0", seg); end
    endtask

    // Frame 0 shows the reset snapshot 00-00-00, frame 1 shows 12-34-56.
    task automatic test_first_frames();
        logic [7:0] f0 [8] = '{8'hC0, 8'hC0, 8'hBF, 8'hC0, 8'hC0, 8'hBF, 8'hC0, 8'hC0};
        logic [7:0] f1 [8] = '{8'h82, 8'h92, 8'hBF, 8'h99, 8'hB0, 8'hBF, 8'hA4, 8'hF9};
        logic [7:0] exp_an;
        logic [7:0] exp_seg;
        int s;
        for (int i = 0; i < 64; i++) begin
            if (i > 0) step();
            s       = slot_now();
            exp_an  = ~(8'd1 << s);
            exp_seg = (t <= 32) ? f0[s] : f1[s];
            total++;
            if (an !== exp_an) begin bad++; $display("FAIL frame_an t=%0d got=%h want=%h", t, an, exp_an); end
            total++;
            if (seg !== exp_seg) begin bad++; $display("FAIL frame_seg t=%0d got=%h want=%h", t, seg, exp_seg); end
        end
    endtask

    // seconds changes right after a snapshot: the whole next frame must still show 56.
    task automatic test_snapshot();
        logic [7:0] f56 [8] = '{8'h82, 8'h92, 8'hBF, 8'h99, 8'hB0, 8'hBF, 8'hA4, 8'hF9};
        logic [7:0] f57 [8] = '{8'hF8, 8'h92, 8'hBF, 8'h99, 8'hB0, 8'hBF, 8'hA4, 8'hF9};
        logic [7:0] exp_seg;
        int s;
        int t0;
        t0      = t;
        seconds = 8'd57;
        for (int i = 0; i < 64; i++) begin
            step();
            s       = slot_now();
            exp_seg = (t <= t0 + 32) ? f56[s] : f57[s];
            total++;
            if (seg !== exp_seg) begin bad++; $display("FAIL snapshot_seg t=%0d got=%h want=%h", t, seg, exp_seg); end
        end
    endtask

    task automatic test_hours_error();
        logic [7:0] f57 [8] = '{8'hF8, 8'h92, 8'hBF, 8'h99, 8'hB0, 8'hBF, 8'hA4, 8'hF9};
        logic [7:0] fe  [8] = '{8'hF8, 8'h92, 8'hBF, 8'h99, 8'hB0, 8'hBF, 8'h86, 8'h86};
        logic [7:0] exp_seg;
        int s;
        int t0;
        t0    = t;
        hours = 8'd150;
        for (int i = 0; i < 64; i++) begin
            step();
            s       = slot_now();
            exp_seg = (t <= t0 + 32) ? f57[s] : fe[s];
            total++;
            if (seg !== exp_seg) begin bad++; $display("FAIL hours_err_seg t=%0d got=%h want=%h", t, seg, exp_seg); end
        end
        hours = 8'd12;
    endtask

    // Blink windows after a field change at edge T: edges T+2..T+17 visible, T+18..T+33 blank, ...
    task automatic test_blink();
        logic [7:0] fn [8] = '{8'hF8, 8'h92, 8'hBF, 8'h99, 8'hB0, 8'hBF, 8'hA4, 8'hF9};
        logic [1:0] modes [3] = '{2'd1, 2'd2, 2'd3};
        logic [7:0] exp_seg;
        logic       blank_win;
        logic       blanked;
        int s;
        int blanks_seen;
        repeat (32) step();
        while (t % 32 != 12) step();
        for (int m = 0; m < 3; m++) begin
            blanks_seen = 0;
            adj_mode    = modes[m];
            for (int k = 1; k <= 64; k++) begin
                step();
                if (k >= 2) begin
                    s         = slot_now();
                    blank_win = (((k - 2) / 16) % 2) == 1;
                    blanked   = blank_win &&
                                ((modes[m] == 2'd1 && (s == 6 || s == 7)) ||
                                 (modes[m] == 2'd2 && (s == 3 || s == 4)));
                    exp_seg   = blanked ? 8'hFF : fn[s];
                    if (blanked) blanks_seen++;
                    total++;
                    if (seg !== exp_seg) begin
                        bad++;
                        $display("FAIL blink_seg mode=%0d k=%0d slot=%0d got=%h want=%h", modes[m], k, s, seg, exp_seg);
                    end
                    total++;
                    if (an !== ~(8'd1 << s)) begin
                        bad++;
                        $display("FAIL blink_an mode=%0d k=%0d got=%h want=%h", modes[m], k, an, ~(8'd1 << s));
                    end
                    total++;
                    if (led !== 1'b0) begin bad++; $display("FAIL blink_led mode=%0d k=%0d got=%b want=0", modes[m], k, led); end
                end
            end
            // Modes 1 and 2 must actually have blanked some digits in the windows above.
            total++;
            if ((blanks_seen > 0) !== (modes[m] != 2'd3)) begin
                bad++;
                $display("FAIL blink_count mode=%0d got=%0d blanked digits", modes[m], blanks_seen);
            end
        end
    endtask

    task automatic test_chime();
        logic exp_led;
        adj_mode = 2'd0;
        chime    = 1'b1;
        for (int k = 1; k <= 64; k++) begin
            step();
            if (k >= 2) begin
                exp_led = (((k - 2) / 16) % 2) == 0;
                total++;
                if (led !== exp_led) begin bad++; $display("FAIL chime_led k=%0d got=%b want=%b", k, led, exp_led); end
            end
        end
        chime = 1'b0;
        step();
        total++;
        if (led !== 1'b0) begin bad++; $display("FAIL chime_fall_led got=%b want=0", led); end
    endtask

    // t%32==22 leaves scan_cnt=2, idx=5 in the design.
    task automatic test_mid_reset();
        chime = 1'b1;
        while (t % 32 != 22) step();
        #2;
        rst = 1'b1;
        #1;
        total++;
        if (an !== 8'hFF) begin bad++; $display("FAIL async_rst_an got=%h want=FF", an); end
        total++;
        if (seg !== 8'hFF) begin bad++; $display("FAIL async_rst_seg got=%h want=FF", seg); end
        total++;
        if (led !== 1'b0) begin bad++; $display("FAIL async_rst_led got=%b want=0", led); end
        chime = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        total++;
        if (an !== 8'hFF || seg !== 8'hFF) begin
            bad++;
            $display("FAIL rst_hold got an=%h seg=%h want FF/FF", an, seg);
        end
        @(negedge clk);
        rst = 1'b0;
        t   = 0;
        step();
        total++;
        if (an !== 8'hFE) begin bad++; $display("FAIL rerelease_an got=%h want=FE", an); end
        total++;
        if (seg !== 8'hC0) begin bad++; $display("FAIL rerelease_seg got=%h want=C0", seg); end
        repeat (4) step();
        total++;
        if (an !== 8'hFD) begin bad++; $display("FAIL rerelease_slot1_an got=%h want=FD", an); end
        total++;
        if (seg !== 8'hC0) begin bad++; $display("FAIL rerelease_slot1_seg got=%h want=C0", seg); end
    endtask

    initial begin
        test_reset();
        test_first_frames();
        test_snapshot();
        test_hours_error();
        test_blink();
        test_chime();
        test_mid_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
